// File: rtl/dmem_arbiter.sv
// Arbiter between the MEM-stage load/store unit (M0, fixed priority) and the debug/loader port (M1)
// in front of the data RAM; a hold counter guarantees M1 a slot after MAX_HOLD consecutive M0 wins.
module dmem_arbiter #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MAX_HOLD = 8
) (
    input  logic              clk_100MHz,
    input  logic              srst,

    input  logic              m0_req_i,
    input  logic              m0_we_i,
    input  logic [ADDR_W-1:0] m0_addr_i,
    input  logic [DATA_W-1:0] m0_wdata_i,
    output logic              m0_gnt_o,
    output logic              m0_rvalid_o,
    output logic [DATA_W-1:0] m0_rdata_o,

    input  logic              m1_req_i,
    input  logic              m1_we_i,
    input  logic [ADDR_W-1:0] m1_addr_i,
    input  logic [DATA_W-1:0] m1_wdata_i,
    output logic              m1_gnt_o,
    output logic              m1_rvalid_o,
    output logic [DATA_W-1:0] m1_rdata_o,

    output logic              ram_rena_o,
    output logic [ADDR_W-1:0] ram_raddr_o,
    output logic              ram_wena_o,
    output logic [ADDR_W-1:0] ram_waddr_o,
    output logic [DATA_W-1:0] ram_wdata_o,
    input  logic [DATA_W-1:0] ram_rdata_i,

    output logic [7:0]        hold_cnt_o
);

    localparam logic [7:0] MAX_HOLD_C = 8'(MAX_HOLD);

    logic [7:0]        hold_cnt_q, hold_cnt_d;
    logic [ADDR_W-1:0] last_waddr_q, last_waddr_d;
    logic [DATA_W-1:0] last_wdata_q, last_wdata_d;
    logic              m0_rvalid_q, m0_rvalid_d;
    logic              m1_rvalid_q, m1_rvalid_d;
    logic [DATA_W-1:0] m0_rdata_q, m0_rdata_d;
    logic [DATA_W-1:0] m1_rdata_q, m1_rdata_d;

    logic              force_m1;
    logic              m0_gnt, m1_gnt, any_gnt;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic              rd_gnt, wr_gnt;

    // Grants are gated by srst so nothing reaches the RAM while the block is held in reset.
    always_comb begin
        force_m1  = (hold_cnt_q == MAX_HOLD_C) & m1_req_i;
        m1_gnt    = ~srst & m1_req_i & (~m0_req_i | force_m1);
        m0_gnt    = ~srst & m0_req_i & ~m1_gnt;
        any_gnt   = m0_gnt | m1_gnt;
        sel_we    = m1_gnt ? m1_we_i    : m0_we_i;
        sel_addr  = m1_gnt ? m1_addr_i  : m0_addr_i;
        sel_wdata = m1_gnt ? m1_wdata_i : m0_wdata_i;
        rd_gnt    = any_gnt & ~sel_we;
        wr_gnt    = any_gnt &  sel_we;
    end

    // An idle write port replays the last write, so a spurious RAM write or a
    // raddr==waddr bypass can never expose anything but the stored word.
    always_comb begin
        ram_rena_o  = rd_gnt;
        ram_raddr_o = any_gnt ? sel_addr : '0;
        ram_wena_o  = wr_gnt;
        ram_waddr_o = wr_gnt ? sel_addr  : last_waddr_q;
        ram_wdata_o = wr_gnt ? sel_wdata : last_wdata_q;
    end

    // NOTE: every next-state signal is assigned a default first so no path leaves it unassigned (no latches).
    always_comb begin
        hold_cnt_d   = hold_cnt_q;
        last_waddr_d = last_waddr_q;
        last_wdata_d = last_wdata_q;
        m0_rvalid_d  = m0_gnt & ~m0_we_i;
        m1_rvalid_d  = m1_gnt & ~m1_we_i;
        m0_rdata_d   = m0_rdata_q;
        m1_rdata_d   = m1_rdata_q;

        if (m0_gnt && m1_req_i) begin
            hold_cnt_d = (hold_cnt_q == MAX_HOLD_C) ? hold_cnt_q : hold_cnt_q + 8'd1;
        end else if (m1_gnt || !m1_req_i) begin
            hold_cnt_d = '0;
        end

        if (wr_gnt) begin
            last_waddr_d = sel_addr;
            last_wdata_d = sel_wdata;
        end

        // rdata is only replaced by that master's own read; writes leave it alone.
        if (m0_rvalid_d) m0_rdata_d = ram_rdata_i;
        if (m1_rvalid_d) m1_rdata_d = ram_rdata_i;
    end

    // NOTE: state registers use non-blocking assignments so all of them update together at the edge.
    always_ff @(posedge clk_100MHz) begin
        if (srst) begin
            hold_cnt_q   <= '0;
            last_waddr_q <= '0;
            last_wdata_q <= '0;
            m0_rvalid_q  <= 1'b0;
            m1_rvalid_q  <= 1'b0;
            m0_rdata_q   <= '0;
            m1_rdata_q   <= '0;
        end else begin
            hold_cnt_q   <= hold_cnt_d;
            last_waddr_q <= last_waddr_d;
            last_wdata_q <= last_wdata_d;
            m0_rvalid_q  <= m0_rvalid_d;
            m1_rvalid_q  <= m1_rvalid_d;
            m0_rdata_q   <= m0_rdata_d;
            m1_rdata_q   <= m1_rdata_d;
        end
    end

    assign m0_gnt_o    = m0_gnt;
    assign m1_gnt_o    = m1_gnt;
    assign m0_rvalid_o = m0_rvalid_q;
    assign m1_rvalid_o = m1_rvalid_q;
    assign m0_rdata_o  = m0_rdata_q;
    assign m1_rdata_o  = m1_rdata_q;
    assign hold_cnt_o  = hold_cnt_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: a behavioural RAM, a request-level reference model whose predicted read
// returns go into per-master queues, and a monitor that pops them when the DUT returns read data.
module tb_dmem_arbiter;

    localparam int ADDR_W   = 32;
    localparam int DATA_W   = 32;
    localparam int MAX_HOLD = 8;

    logic              clk_100MHz = 1'b0;
    logic              srst = 1'b1;
    logic              m0_req_i = 1'b0, m0_we_i = 1'b0;
    logic [ADDR_W-1:0] m0_addr_i = '0;
    logic [DATA_W-1:0] m0_wdata_i = '0;
    logic              m1_req_i = 1'b0, m1_we_i = 1'b0;
    logic [ADDR_W-1:0] m1_addr_i = '0;
    logic [DATA_W-1:0] m1_wdata_i = '0;
    logic              m0_gnt_o, m0_rvalid_o, m1_gnt_o, m1_rvalid_o;
    logic [DATA_W-1:0] m0_rdata_o, m1_rdata_o;
    logic              ram_rena_o, ram_wena_o;
    logic [ADDR_W-1:0] ram_raddr_o, ram_waddr_o;
    logic [DATA_W-1:0] ram_wdata_o, ram_rdata_i;
    logic [7:0]        hold_cnt_o;

    always #5 clk_100MHz = ~clk_100MHz;

    dmem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_HOLD(MAX_HOLD)) dut (
        .clk_100MHz (clk_100MHz),
        .srst       (srst),
        .m0_req_i   (m0_req_i),
        .m0_we_i    (m0_we_i),
        .m0_addr_i  (m0_addr_i),
        .m0_wdata_i (m0_wdata_i),
        .m0_gnt_o   (m0_gnt_o),
        .m0_rvalid_o(m0_rvalid_o),
        .m0_rdata_o (m0_rdata_o),
        .m1_req_i   (m1_req_i),
        .m1_we_i    (m1_we_i),
        .m1_addr_i  (m1_addr_i),
        .m1_wdata_i (m1_wdata_i),
        .m1_gnt_o   (m1_gnt_o),
        .m1_rvalid_o(m1_rvalid_o),
        .m1_rdata_o (m1_rdata_o),
        .ram_rena_o (ram_rena_o),
        .ram_raddr_o(ram_raddr_o),
        .ram_wena_o (ram_wena_o),
        .ram_waddr_o(ram_waddr_o),
        .ram_wdata_o(ram_wdata_o),
        .ram_rdata_i(ram_rdata_i),
        .hold_cnt_o (hold_cnt_o)
    );

    function automatic logic [31:0] init_word(input int i);
        return 32'h5A5A_0000 + 32'(i) * 32'h0101_0003;
    endfunction

    // Behavioural RAM: combinational read, clocked write, preloaded on the first edge.
    logic [31:0] ram_mem [0:255];
    bit          ram_loaded = 1'b0;
    assign ram_rdata_i = ram_mem[ram_raddr_o[9:2]];
    always @(posedge clk_100MHz) begin
        if (!ram_loaded) begin
            for (int i = 0; i < 256; i++) ram_mem[i] <= init_word(i);
            ram_loaded <= 1'b1;
        end else if (ram_wena_o) begin
            ram_mem[ram_waddr_o[9:2]] <= ram_wdata_o;
        end
    end

    int cyc = 0;
    always @(posedge clk_100MHz) cyc++;

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model state
    typedef struct {
        logic [31:0] data;
        int          due;
    } rd_exp_t;

    rd_exp_t     q0[$];
    rd_exp_t     q1[$];
    logic [31:0] mdl_mem [0:255];
    int          mdl_wait = 0;
    logic [31:0] mdl_last_waddr = '0;
    logic [31:0] mdl_last_wdata = '0;

    // One cycle: drive at negedge, check the combinational response, advance the model.
    task automatic step(input logic rst,
                        input logic r0, input logic w0, input logic [31:0] a0, input logic [31:0] d0,
                        input logic r1, input logic w1, input logic [31:0] a1, input logic [31:0] d1,
                        output logic g0, output logic g1);
        logic        gw;
        logic [31:0] ga, gd;
        @(negedge clk_100MHz);
        srst = rst;
        m0_req_i = r0; m0_we_i = w0; m0_addr_i = a0; m0_wdata_i = d0;
        m1_req_i = r1; m1_we_i = w1; m1_addr_i = a1; m1_wdata_i = d1;
        #1;
        g1 = !rst && r1 && (!r0 || mdl_wait == MAX_HOLD);
        g0 = !rst && r0 && !g1;
        check("m0_gnt", m0_gnt_o, g0);
        check("m1_gnt", m1_gnt_o, g1);
        if (rst) begin
            check("rst_rena", ram_rena_o, 0);
            check("rst_wena", ram_wena_o, 0);
            mdl_wait = 0;
            mdl_last_waddr = '0;
            mdl_last_wdata = '0;
        end else begin
            check("hold_cnt", hold_cnt_o, 64'(mdl_wait));
            gw = g1 ? w1 : w0;
            ga = g1 ? a1 : a0;
            gd = g1 ? d1 : d0;
            if ((g0 || g1) && gw) begin
                check("wr_wena", ram_wena_o, 1);
                check("wr_rena", ram_rena_o, 0);
                check("wr_waddr", ram_waddr_o, ga);
                check("wr_wdata", ram_wdata_o, gd);
                check("wr_raddr", ram_raddr_o, ga);
                mdl_mem[ga[9:2]] = gd;
                mdl_last_waddr = ga;
                mdl_last_wdata = gd;
            end else begin
                check("idle_wena", ram_wena_o, 0);
                check("idle_waddr", ram_waddr_o, mdl_last_waddr);
                check("idle_wdata", ram_wdata_o, mdl_last_wdata);
                if (g0 || g1) begin
                    check("rd_rena", ram_rena_o, 1);
                    check("rd_raddr", ram_raddr_o, ga);
                    if (g0) q0.push_back('{data: mdl_mem[ga[9:2]], due: cyc + 1});
                    else    q1.push_back('{data: mdl_mem[ga[9:2]], due: cyc + 1});
                end else begin
                    check("idle_rena", ram_rena_o, 0);
                    check("idle_raddr", ram_raddr_o, 0);
                end
            end
            // M1's wait grows with each M0 win it sits through, capped at MAX_HOLD.
            if (g0 && r1)         mdl_wait = (mdl_wait < MAX_HOLD) ? mdl_wait + 1 : MAX_HOLD;
            else if (g1 || !r1)   mdl_wait = 0;
        end
    endtask

    // Monitor: every cycle after the edge, compare read returns against the queued predictions.
    logic [31:0] last0 = '0, last1 = '0;
    initial begin
        logic rst_edge;
        forever begin
            @(posedge clk_100MHz);
            rst_edge = srst;
            #1;
            if (rst_edge) begin
                check("rst_m0_rvalid", m0_rvalid_o, 0);
                check("rst_m1_rvalid", m1_rvalid_o, 0);
                check("rst_m0_rdata", m0_rdata_o, 0);
                check("rst_m1_rdata", m1_rdata_o, 0);
                last0 = '0;
                last1 = '0;
                q0.delete();
                q1.delete();
            end else begin
                if (q0.size() != 0 && q0[0].due == cyc) begin
                    check("m0_rvalid", m0_rvalid_o, 1);
                    check("m0_rdata", m0_rdata_o, q0[0].data);
                    last0 = q0[0].data;
                    void'(q0.pop_front());
                end else begin
                    check("m0_rvalid_idle", m0_rvalid_o, 0);
                    check("m0_rdata_hold", m0_rdata_o, last0);
                end
                if (q1.size() != 0 && q1[0].due == cyc) begin
                    check("m1_rvalid", m1_rvalid_o, 1);
                    check("m1_rdata", m1_rdata_o, q1[0].data);
                    last1 = q1[0].data;
                    void'(q1.pop_front());
                end else begin
                    check("m1_rvalid_idle", m1_rvalid_o, 0);
                    check("m1_rdata_hold", m1_rdata_o, last1);
                end
            end
        end
    end

    initial begin
        logic        g0, g1;
        logic        p0, p0_we, p1, p1_we, rst;
        logic [31:0] p0_a, p0_d, p1_a, p1_d;
        int          rate0, rate1;

        for (int i = 0; i < 256; i++) mdl_mem[i] = init_word(i);

        // Reset held two cycles with M0 requesting, then M0 wins immediately.
        step(1, 1, 0, 32'h40, 0, 0, 0, 0, 0, g0, g1);
        step(1, 1, 0, 32'h40, 0, 0, 0, 0, 0, g0, g1);
        check("t1_hold_in_rst", hold_cnt_o, 0);
        step(0, 1, 0, 32'h40, 0, 0, 0, 0, 0, g0, g1);
        check("t1_m0_gnt_after_rst", m0_gnt_o, 1);

        // Write then read-back of the same address.
        step(0, 1, 1, 32'h10, 32'hDEAD_BEEF, 0, 0, 0, 0, g0, g1);
        step(0, 1, 0, 32'h10, 0, 0, 0, 0, 0, g0, g1);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, g0, g1);
        check("t2_rvalid", m0_rvalid_o, 1);
        check("t2_rdata", m0_rdata_o, 32'hDEAD_BEEF);
        check("t2_idle_waddr", ram_waddr_o, 32'h10);
        check("t2_idle_wdata", ram_wdata_o, 32'hDEAD_BEEF);

        // Both masters saturated: M1 gets every ninth slot.
        for (int i = 0; i < 20; i++) begin
            step(0, 1, 0, 32'h10, 0, 1, 0, 32'h80, 0, g0, g1);
            check("t3_m1_gnt", m1_gnt_o, (i % 9) == 8);
            check("t3_hold", hold_cnt_o, 64'(i % 9));
        end

        // M1 alone, back-to-back reads.
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 0, 0, 0, 1, 0, 32'(i * 4), 0, g0, g1);
            check("t4_m1_gnt", m1_gnt_o, 1);
        end
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, g0, g1);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, g0, g1);

        // Reset right behind an M1 read drops the returned data.
        step(0, 0, 0, 0, 0, 1, 0, 32'h4, 0, g0, g1);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, g0, g1);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, g0, g1);
        check("t5_m1_rvalid", m1_rvalid_o, 0);
        check("t5_m1_rdata", m1_rdata_o, 0);

        // M1 waits through three M0 reads of 0x20, then withdraws.
        for (int i = 0; i < 3; i++) step(0, 1, 0, 32'h20, 0, 1, 1, 32'h24, 32'h1234_5678, g0, g1);
        step(0, 1, 0, 32'h20, 0, 0, 0, 0, 0, g0, g1);
        check("t6_hold_before_drop", hold_cnt_o, 3);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, g0, g1);
        check("t6_hold_after_drop", hold_cnt_o, 0);
        check("t6_rvalid", m0_rvalid_o, 1);
        check("t6_rdata", m0_rdata_o, init_word(8));

        // Randomized traffic; requests stay stable until granted.
        p0 = 0; p1 = 0;
        p0_we = 0; p1_we = 0; p0_a = 0; p1_a = 0; p0_d = 0; p1_d = 0;
        for (int n = 0; n < 2000; n++) begin
            rate0 = (n < 700) ? 95 : (n < 1400) ? 50 : 20;
            rate1 = (n < 700) ? 60 : (n < 1400) ? 30 : 80;
            if (!p0 && $urandom_range(0, 99) < rate0) begin
                p0 = 1; p0_we = 1'($urandom_range(0, 1));
                p0_a = 32'($urandom_range(0, 15) * 4); p0_d = $urandom;
            end
            if (!p1 && $urandom_range(0, 99) < rate1) begin
                p1 = 1; p1_we = 1'($urandom_range(0, 1));
                p1_a = 32'($urandom_range(0, 15) * 4); p1_d = $urandom;
            end
            rst = ($urandom_range(0, 299) == 0);
            step(rst, p0, p0_we, p0_a, p0_d, p1, p1_we, p1_a, p1_d, g0, g1);
            if (g0) p0 = 0;
            if (g1) p1 = 0;
        end

        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, g0, g1);
        check("drain_q0", 64'(q0.size()), 0);
        check("drain_q1", 64'(q1.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-requester arbiter in front of the single data RAM: one read port, one write port, combinational read, clocked write.
- Requester M0 is the pipeline MEM-stage load/store unit. Requester M1 is the debug/program-loader port.
- M0 has fixed priority. An anti-starvation counter guarantees M1 a slot.
- One transaction (read or write) is issued to the RAM per cycle. Read data is registered and returned one cycle after the grant.

Parameters:
- ADDR_W, 32, byte address width; RAM word index is addr[ADDR_W-1:2]
- DATA_W, 32, data word width
- MAX_HOLD, 8, max consecutive M0 grants while M1 is requesting; range 1..255

Ports:
- clk_100MHz  in  1  system clock; all state on posedge
- srst  in  1  synchronous reset, active-high
- m0_req_i  in  1  M0 transaction request
- m0_we_i  in  1  1 = write, 0 = read
- m0_addr_i  in  ADDR_W  M0 byte address
- m0_wdata_i  in  DATA_W  M0 write data
- m0_gnt_o  out  1  M0 transaction accepted this cycle (combinational)
- m0_rvalid_o  out  1  M0 read data valid (one-cycle pulse)
- m0_rdata_o  out  DATA_W  M0 read data
- m1_req_i, m1_we_i, m1_addr_i, m1_wdata_i, m1_gnt_o, m1_rvalid_o, m1_rdata_o  same as M0, for M1
- ram_rena_o  out  1  RAM read enable
- ram_raddr_o  out  ADDR_W  RAM read address
- ram_wena_o  out  1  RAM write enable
- ram_waddr_o  out  ADDR_W  RAM write address
- ram_wdata_o  out  DATA_W  RAM write data
- ram_rdata_i  in  DATA_W  RAM combinational read data
- hold_cnt_o  out  8  current starvation-counter value (debug)

Behaviour:
- Reset (srst=1 at posedge):
  - hold_cnt=0, last_waddr=0, last_wdata=0.
  - m0/m1_rvalid_o=0, m0/m1_rdata_o=0.
  - While srst is high, both gnt are forced 0 and ram_rena_o/ram_wena_o are forced 0.
  - Reset mid-transaction drops any pending rvalid.
- Grant (combinational, same cycle as req):
  - force_m1 = (hold_cnt==MAX_HOLD) & m1_req_i.
  - m1_gnt = m1_req_i & (~m0_req_i | force_m1).
  - m0_gnt = m0_req_i & ~m1_gnt.
  - Exactly zero or one grant per cycle. A requester keeps req, we, addr and wdata stable until it sees gnt.
- Counter (posedge):
  - If m0_gnt & m1_req_i: hold_cnt+1, saturating at MAX_HOLD.
  - If m1_gnt or ~m1_req_i: hold_cnt=0.
  - Otherwise hold.
  - Consequence: M1 waits at most MAX_HOLD cycles. After a forced M1 grant, M0 regains priority.
- RAM drive for the granted master g:
  - Read: ram_rena_o=1, ram_raddr_o=g.addr, ram_wena_o=0.
  - Write: ram_wena_o=1, ram_waddr_o=g.addr, ram_wdata_o=g.wdata, ram_rena_o=0, ram_raddr_o=g.addr.
  - On the write's posedge, last_waddr/last_wdata capture the address and data.
- Idle write port (no write granted this cycle):
  - ram_waddr_o=last_waddr, ram_wdata_o=last_wdata, ram_wena_o=0.
  - Any write the RAM performs is then idempotent, and read-forwarding on raddr==waddr returns data identical to memory.
- Idle read port: ram_rena_o=0, ram_raddr_o=0.
- Read return:
  - At the posedge ending a granted read, ram_rdata_i is captured into the granted master's rdata register.
  - That master's rvalid_o pulses 1 for the following cycle.
  - rdata_o holds its value until that master's next read; it is not cleared by writes.
- Latency:
  - Grant and write: 0 cycles (same cycle).
  - Read data: 1 cycle after the grant cycle.
  - Back-to-back reads sustain 1 per cycle.
- Simultaneous events:
  - Both req with hold_cnt<MAX_HOLD: M0 granted.
  - Both req with hold_cnt==MAX_HOLD: M1 granted.
  - A write then a read of the same address on the next cycle returns the new data.

Test Plan:
1. Reset: assert srst 2 cycles with m0_req_i=1 -> both gnt=0, ram_rena_o=ram_wena_o=0, rvalid=0, hold_cnt_o=0; after release, M0 granted the same cycle.
2. M0 write 0x0000_0010 <= 0xDEAD_BEEF, then M0 read 0x10 next cycle -> m0_gnt=1 both cycles; m0_rvalid_o=1 with m0_rdata_o=0xDEAD_BEEF one cycle after the read grant; ram_waddr_o stays 0x10 and ram_wdata_o stays 0xDEAD_BEEF while idle.
3. Starvation, MAX_HOLD=8: m0_req_i and m1_req_i held high 20 cycles -> M0 granted cycles 0-7, M1 granted cycle 8, M0 cycles 9-16, M1 cycle 17; hold_cnt_o sequence 0..8,0,1..8,0.
4. M1 alone: 4 back-to-back reads of 0x0,0x4,0x8,0xC -> m1_gnt=1 every cycle, m1_rvalid_o high 4 consecutive cycles with in-order data; m0_rvalid_o stays 0.
5. Reset mid-read: M1 read granted, srst asserted the next cycle -> m1_rvalid_o=0 and m1_rdata_o=0 after that edge.
6. Interleaving: M0 reads 0x20 while M1 waits with hold_cnt=3, M1 drops req -> hold_cnt returns to 0 next cycle; M0 rvalid carries the RAM content of 0x20.
